// File: rtl/softmax_max_buffer_if.sv
// Stream bus for softmax_max_buffer: input word stream, frame-max result and
// the replayed word stream with its valid/ready handshake.
interface softmax_max_buffer_if #(
  parameter int unsigned DATA_SIZE = 32
);
  logic                 start_i;
  logic [DATA_SIZE-1:0] data_i;
  logic                 ready_o;
  logic                 max_valid_o;
  logic [DATA_SIZE-1:0] max_o;
  logic                 ready_i;
  logic                 data_valid_o;
  logic [DATA_SIZE-1:0] data_o;
  logic                 last_o;

  modport master (
    output start_i, data_i, ready_i,
    input  ready_o, max_valid_o, max_o, data_valid_o, data_o, last_o
  );

  modport slave (
    input  start_i, data_i, ready_i,
    output ready_o, max_valid_o, max_o, data_valid_o, data_o, last_o
  );
endinterface

// File: rtl/softmax_max_buffer.sv
// Buffers one frame of IEEE-754 words while tracking its maximum, then
// publishes the maximum and replays the frame in arrival order.
module softmax_max_buffer #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned NUMBER_OF_DATA = 10,
  parameter int unsigned ADDR_SIZE      = $clog2(NUMBER_OF_DATA)
) (
  input logic                 clock_i,
  input logic                 reset_n_i,
  softmax_max_buffer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, REPLAY} state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(NUMBER_OF_DATA - 1);

  state_t               state;
  logic [ADDR_SIZE-1:0] count;
  logic [ADDR_SIZE-1:0] rd_idx;
  logic [DATA_SIZE-1:0] run_max;
  logic [DATA_SIZE-1:0] mem [NUMBER_OF_DATA];

  logic                 accept_c;
  logic                 handshake_c;
  logic [ADDR_SIZE-1:0] rd_next_c;
  logic [DATA_SIZE-1:0] new_max_c;

  // IEEE-754 "a strictly greater than b"; signed zeros are equal, no NaN/inf handling.
  function automatic logic is_greater(input logic [DATA_SIZE-1:0] a,
                                      input logic [DATA_SIZE-1:0] b);
    logic                 sa, sb;
    logic [DATA_SIZE-2:0] ma, mb;
    sa = a[DATA_SIZE-1];
    sb = b[DATA_SIZE-1];
    ma = a[DATA_SIZE-2:0];
    mb = b[DATA_SIZE-2:0];
    if (ma == '0 && mb == '0) return 1'b0;
    if (sa != sb)             return ~sa;
    if (!sa)                  return ma > mb;
    return ma < mb;
  endfunction

  assign accept_c    = bus.start_i & bus.ready_o & (state != REPLAY);
  assign handshake_c = bus.data_valid_o & bus.ready_i;
  assign rd_next_c   = rd_idx + ADDR_SIZE'(1);
  assign new_max_c   = is_greater(bus.data_i, run_max) ? bus.data_i : run_max;

  // Frame storage; only written while loading, so never shared with a replay read.
  always_ff @(posedge clock_i) begin
    if (accept_c) mem[count] <= bus.data_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= IDLE;
      count            <= '0;
      rd_idx           <= '0;
      run_max          <= '0;
      bus.ready_o      <= 1'b0;
      bus.max_valid_o  <= 1'b0;
      bus.max_o        <= '0;
      bus.data_valid_o <= 1'b0;
      bus.data_o       <= '0;
      bus.last_o       <= 1'b0;
    end else begin
      bus.max_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          bus.ready_o <= 1'b1;
          if (accept_c) begin
            run_max <= bus.data_i;
            count   <= ADDR_SIZE'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          bus.ready_o <= 1'b1;
          if (accept_c) begin
            run_max <= new_max_c;
            if (count == LAST_IDX) begin
              // Frame complete: publish max and present the first stored word together.
              count            <= '0;
              rd_idx           <= '0;
              state            <= REPLAY;
              bus.ready_o      <= 1'b0;
              bus.max_valid_o  <= 1'b1;
              bus.max_o        <= new_max_c;
              bus.data_valid_o <= 1'b1;
              bus.data_o       <= mem[0];
              bus.last_o       <= 1'b0;
            end else begin
              count <= count + ADDR_SIZE'(1);
            end
          end
        end
        REPLAY: begin
          if (handshake_c) begin
            if (rd_idx == LAST_IDX) begin
              state            <= IDLE;
              rd_idx           <= '0;
              bus.ready_o      <= 1'b1;
              bus.data_valid_o <= 1'b0;
              bus.last_o       <= 1'b0;
            end else begin
              rd_idx     <= rd_next_c;
              bus.data_o <= mem[rd_next_c];
              bus.last_o <= (rd_next_c == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
